// File: rtl/vigna_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vigna_bus_arbiter: shares one memory bus between the instruction and data
// ports with round-robin/fixed priority and an optional per-grant timeout.
// Revision 1.0
// ----------------------------------------------------------------------------
module vigna_bus_arbiter #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 0,
  parameter int TO_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        err,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = (TIMEOUT > 0) ? TO_WIDTH'(TIMEOUT - 1) : '0;

  state_t              state, state_nx;
  logic                last_grant, last_grant_nx;  // 1 = data port won last
  logic [TO_WIDTH-1:0] cnt, cnt_nx;
  logic                m_valid_nx;
  logic [31:0]         m_addr_nx;
  logic [31:0]         m_wdata_nx;
  logic [3:0]          m_wstrb_nx;
  logic                grant_d_nx;
  logic                granted;
  logic                timeout_hit;
  logic                done;
  logic                pick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      grant_d    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      cnt        <= cnt_nx;
      m_valid    <= m_valid_nx;
      m_addr     <= m_addr_nx;
      m_wdata    <= m_wdata_nx;
      m_wstrb    <= m_wstrb_nx;
      grant_d    <= grant_d_nx;
    end
  end

  // Completion path: m_ready/m_rdata reach the granted requester combinationally.
  always_comb begin
    granted     = (state != IDLE);
    timeout_hit = (TIMEOUT > 0) && granted && !m_ready && (cnt == TO_LAST);
    done        = granted && (m_ready || timeout_hit);
    i_ready     = (state == GRANT_I) && done && i_valid;
    d_ready     = (state == GRANT_D) && done && d_valid;
    i_rdata     = ((state == GRANT_I) && m_ready) ? m_rdata : 32'h0;
    d_rdata     = ((state == GRANT_D) && m_ready) ? m_rdata : 32'h0;
    err         = timeout_hit;
  end

  // Ties go to D under fixed priority, otherwise to the port that did not win last.
  always_comb begin
    pick_d        = d_valid && (!i_valid || (PRIORITY == 1) || !last_grant);
    state_nx      = state;
    last_grant_nx = last_grant;
    cnt_nx        = cnt;
    m_valid_nx    = m_valid;
    m_addr_nx     = m_addr;
    m_wdata_nx    = m_wdata;
    m_wstrb_nx    = m_wstrb;
    grant_d_nx    = grant_d;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pick_d) begin
          state_nx      = GRANT_D;
          last_grant_nx = 1'b1;
          m_valid_nx    = 1'b1;
          m_addr_nx     = d_addr;
          m_wdata_nx    = d_wdata;
          m_wstrb_nx    = d_wstrb;
          grant_d_nx    = 1'b1;
        end else if (i_valid) begin
          state_nx      = GRANT_I;
          last_grant_nx = 1'b0;
          m_valid_nx    = 1'b1;
          m_addr_nx     = i_addr;
          m_wdata_nx    = 32'h0;
          m_wstrb_nx    = 4'h0;
          grant_d_nx    = 1'b0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (done) begin
          state_nx   = IDLE;
          m_valid_nx = 1'b0;
          m_wstrb_nx = 4'h0;
          grant_d_nx = 1'b0;
          cnt_nx     = '0;
        end else if (TIMEOUT > 0) begin
          cnt_nx = cnt + TO_WIDTH'(1);
        end
      end
      default: begin
        state_nx   = IDLE;
        m_valid_nx = 1'b0;
        m_wstrb_nx = 4'h0;
        grant_d_nx = 1'b0;
        cnt_nx     = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vigna_bus_arbiter.sv
`default_nettype none
// Directed bench: u0 is round-robin with TIMEOUT=8, u1 is fixed data priority
// with no timeout; both share the requester and memory-side stimulus.
module tb_vigna_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0, d_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0]  d_wstrb = '0;

  logic        i_ready0, d_ready0, m_valid0, err0, grant_d0;
  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;
  logic [3:0]  m_wstrb0;
  logic        i_ready1, d_ready1, m_valid1, err1, grant_d1;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic [3:0]  m_wstrb1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vigna_bus_arbiter #(.PRIORITY(0), .TIMEOUT(8), .TO_WIDTH(16)) u0 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready0), .i_addr(i_addr), .i_rdata(i_rdata0),
    .d_valid(d_valid), .d_ready(d_ready0), .d_addr(d_addr), .d_rdata(d_rdata0),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid0), .m_ready(m_ready), .m_addr(m_addr0), .m_rdata(m_rdata),
    .m_wdata(m_wdata0), .m_wstrb(m_wstrb0), .err(err0), .grant_d(grant_d0)
  );

  vigna_bus_arbiter #(.PRIORITY(1), .TIMEOUT(0), .TO_WIDTH(16)) u1 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready1), .i_addr(i_addr), .i_rdata(i_rdata1),
    .d_valid(d_valid), .d_ready(d_ready1), .d_addr(d_addr), .d_rdata(d_rdata1),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid1), .m_ready(m_ready), .m_addr(m_addr1), .m_rdata(m_rdata),
    .m_wdata(m_wdata1), .m_wstrb(m_wstrb1), .err(err1), .grant_d(grant_d1)
  );

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) step();
    checks++; if (m_valid0 !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid0); else passed++;
    checks++; if (m_addr0 !== 32'h0) $display("FAIL rst_m_addr: got %h want 0", m_addr0); else passed++;
    checks++; if (m_wdata0 !== 32'h0 || m_wstrb0 !== 4'h0) $display("FAIL rst_m_wdata_wstrb: got %h/%h want 0/0", m_wdata0, m_wstrb0); else passed++;
    checks++; if (grant_d0 !== 1'b0 || err0 !== 1'b0) $display("FAIL rst_grant_err: got %b/%b want 0/0", grant_d0, err0); else passed++;
    i_valid = 1'b1; m_ready = 1'b1; #1;
    checks++; if (i_ready0 !== 1'b0) $display("FAIL rst_i_ready: got %b want 0", i_ready0); else passed++;
    i_valid = 1'b0; m_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    i_valid = 1'b1; i_addr = 32'h100; #1;
    checks++; if (m_valid0 !== 1'b0) $display("FAIL fetch_no_comb_path: got %b want 0", m_valid0); else passed++;
    step();
    checks++; if (m_valid0 !== 1'b1 || m_addr0 !== 32'h100) $display("FAIL fetch_grant: got v=%b a=%h want v=1 a=100", m_valid0, m_addr0); else passed++;
    checks++; if (m_wstrb0 !== 4'h0 || grant_d0 !== 1'b0) $display("FAIL fetch_wstrb: got %h/%b want 0/0", m_wstrb0, grant_d0); else passed++;
    m_ready = 1'b1; m_rdata = 32'h13; #1;
    checks++; if (i_ready0 !== 1'b1 || i_rdata0 !== 32'h13) $display("FAIL fetch_ready: got %b/%h want 1/00000013", i_ready0, i_rdata0); else passed++;
    checks++; if (d_ready0 !== 1'b0 || d_rdata0 !== 32'h0) $display("FAIL fetch_d_quiet: got %b/%h want 0/0", d_ready0, d_rdata0); else passed++;
    step();
    i_valid = 1'b0; m_ready = 1'b0; m_rdata = '0; #1;
    checks++; if (i_ready0 !== 1'b0 || m_valid0 !== 1'b0) $display("FAIL fetch_single_pulse: got rdy=%b v=%b want 0/0", i_ready0, m_valid0); else passed++;
  endtask

  task automatic test_store;
    d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    step();
    checks++; if (grant_d0 !== 1'b1) $display("FAIL store_grant_d: got %b want 1", grant_d0); else passed++;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (m_addr0 !== 32'h2000 || m_wdata0 !== 32'hDEADBEEF || m_wstrb0 !== 4'hF || d_ready0 !== 1'b0)
        $display("FAIL store_hold%0d: got a=%h d=%h s=%h r=%b want 2000/deadbeef/f/0", c, m_addr0, m_wdata0, m_wstrb0, d_ready0);
      else passed++;
      step();
    end
    m_ready = 1'b1; #1;
    checks++; if (d_ready0 !== 1'b1 || i_ready0 !== 1'b0) $display("FAIL store_ready: got d=%b i=%b want 1/0", d_ready0, i_ready0); else passed++;
    step();
    d_valid = 1'b0; d_wstrb = 4'h0; m_ready = 1'b0; #1;
    checks++; if (grant_d0 !== 1'b0 || m_wstrb0 !== 4'h0 || m_valid0 !== 1'b0) $display("FAIL store_release: got g=%b s=%h v=%b want 0/0/0", grant_d0, m_wstrb0, m_valid0); else passed++;
  endtask

  task automatic test_round_robin;
    logic exp_d;
    do_reset();
    i_valid = 1'b1; i_addr = 32'h400; d_valid = 1'b1; d_addr = 32'h800; d_wdata = '0; d_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      exp_d = ((k % 2) == 0);
      step();
      checks++;
      if (grant_d0 !== exp_d || m_addr0 !== (exp_d ? 32'h800 : 32'h400))
        $display("FAIL rr_grant%0d: got g=%b a=%h want g=%b", k, grant_d0, m_addr0, exp_d);
      else passed++;
      m_ready = 1'b1; m_rdata = 32'h10 + 32'(k); #1;
      checks++;
      if (d_ready0 !== exp_d || i_ready0 !== !exp_d)
        $display("FAIL rr_ready%0d: got d=%b i=%b want d=%b", k, d_ready0, i_ready0, exp_d);
      else passed++;
      step();
      m_ready = 1'b0; #1;
      checks++; if (m_valid0 !== 1'b0) $display("FAIL rr_idle_gap%0d: got %b want 0", k, m_valid0); else passed++;
    end
    i_valid = 1'b0; d_valid = 1'b0;
    step();
  endtask

  task automatic test_fixed_priority;
    do_reset();
    i_valid = 1'b1; i_addr = 32'h400; d_valid = 1'b1; d_addr = 32'h800;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (grant_d1 !== 1'b1 || m_addr1 !== 32'h800) $display("FAIL prio_grant%0d: got g=%b a=%h want 1/800", k, grant_d1, m_addr1); else passed++;
      m_ready = 1'b1; #1;
      checks++; if (d_ready1 !== 1'b1 || i_ready1 !== 1'b0) $display("FAIL prio_ready%0d: got d=%b i=%b want 1/0", k, d_ready1, i_ready1); else passed++;
      step();
      m_ready = 1'b0;
    end
    d_valid = 1'b0;
    step();
    checks++; if (grant_d1 !== 1'b0 || m_valid1 !== 1'b1 || m_addr1 !== 32'h400) $display("FAIL prio_i_after_drop: got g=%b v=%b a=%h want 0/1/400", grant_d1, m_valid1, m_addr1); else passed++;
    m_ready = 1'b1; m_rdata = 32'h77; #1;
    checks++; if (i_ready1 !== 1'b1 || i_rdata1 !== 32'h77) $display("FAIL prio_i_ready: got %b/%h want 1/00000077", i_ready1, i_rdata1); else passed++;
    step();
    m_ready = 1'b0; i_valid = 1'b0;
    step();
  endtask

  task automatic test_timeout;
    do_reset();
    d_valid = 1'b1; d_addr = 32'h3000; d_wstrb = 4'h0; i_valid = 1'b1; i_addr = 32'h500;
    m_rdata = 32'hCAFEF00D; m_ready = 1'b0;
    step();
    checks++; if (grant_d0 !== 1'b1) $display("FAIL to_grant_d: got %b want 1", grant_d0); else passed++;
    for (int c = 1; c < 8; c++) begin
      checks++;
      if (err0 !== 1'b0 || d_ready0 !== 1'b0) $display("FAIL to_early%0d: got err=%b rdy=%b want 0/0", c, err0, d_ready0);
      else passed++;
      step();
    end
    checks++; if (d_ready0 !== 1'b1 || d_rdata0 !== 32'h0 || err0 !== 1'b1) $display("FAIL to_abort: got rdy=%b rd=%h err=%b want 1/0/1", d_ready0, d_rdata0, err0); else passed++;
    checks++; if (err1 !== 1'b0 || d_ready1 !== 1'b0) $display("FAIL to_disabled: got err=%b rdy=%b want 0/0", err1, d_ready1); else passed++;
    step();
    d_valid = 1'b0; #1;
    checks++; if (m_valid0 !== 1'b0 || err0 !== 1'b0) $display("FAIL to_idle: got v=%b err=%b want 0/0", m_valid0, err0); else passed++;
    step();
    checks++; if (m_valid0 !== 1'b1 || grant_d0 !== 1'b0 || m_addr0 !== 32'h500) $display("FAIL to_i_next: got v=%b g=%b a=%h want 1/0/500", m_valid0, grant_d0, m_addr0); else passed++;
    m_ready = 1'b1; #1;
    checks++; if (i_ready0 !== 1'b1 || i_rdata0 !== 32'hCAFEF00D) $display("FAIL to_i_ready: got %b/%h want 1/cafef00d", i_ready0, i_rdata0); else passed++;
    step();
    m_ready = 1'b0; i_valid = 1'b0; m_rdata = '0;
    step();
  endtask

  task automatic test_reset_midgrant;
    do_reset();
    i_valid = 1'b1; i_addr = 32'h600;
    step();
    d_valid = 1'b1; d_addr = 32'h700; d_wstrb = 4'h3; d_wdata = 32'h1234;
    step();
    checks++; if (m_valid0 !== 1'b1 || grant_d0 !== 1'b0) $display("FAIL mid_in_grant_i: got v=%b g=%b want 1/0", m_valid0, grant_d0); else passed++;
    m_ready = 1'b1; m_rdata = 32'h55; reset = 1'b1; #1;
    checks++; if (m_valid0 !== 1'b0 || i_ready0 !== 1'b0 || m_addr0 !== 32'h0) $display("FAIL mid_reset: got v=%b rdy=%b a=%h want 0/0/0", m_valid0, i_ready0, m_addr0); else passed++;
    m_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if (grant_d0 !== 1'b1 || m_addr0 !== 32'h700 || m_wstrb0 !== 4'h3) $display("FAIL mid_first_d: got g=%b a=%h s=%h want 1/700/3", grant_d0, m_addr0, m_wstrb0); else passed++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_midgrant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vigna_bus_arbiter.md
Name: vigna_bus_arbiter

Overview:
- Shares one memory bus between the vigna core's instruction port (read-only) and data port (read/write). Sits between the core and the single-ported memory/peripheral interconnect.
- Registers the winning request onto the master port and returns the completion to the granted requester only.
- Includes a per-transaction timeout that terminates hung accesses with an error pulse.

Parameters:
- PRIORITY, 0, tie-break policy: 0 = round-robin, 1 = data port always wins.
- TIMEOUT, 0, number of cycles in a grant state before abort; 0 disables the timeout.
- TO_WIDTH, 16, width of the timeout counter; TIMEOUT < 2^TO_WIDTH.

Ports:
- clk  input  1  clock, all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- i_valid  input  1  instruction request
- i_ready  output  1  instruction completion, one-cycle pulse
- i_addr  input  32  instruction address
- i_rdata  output  32  instruction read data
- d_valid  input  1  data request
- d_ready  output  1  data completion, one-cycle pulse
- d_addr  input  32  data address
- d_rdata  output  32  data read data
- d_wdata  input  32  store data
- d_wstrb  input  4  byte strobes; 0 = read
- m_valid  output  1  master request
- m_ready  input  1  master completion
- m_addr  output  32  master address
- m_rdata  input  32  master read data
- m_wdata  output  32  master store data
- m_wstrb  output  4  master strobes
- err  output  1  timeout-abort pulse
- grant_d  output  1  1 while the data port owns the bus

Behaviour:
- Reset (asynchronous, while reset=1):
  - state=IDLE; m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0.
  - err=0, grant_d=0, timeout counter=0.
  - last_grant=I, so the first round-robin tie goes to D.
- States are IDLE, GRANT_I and GRANT_D, all registered.
- IDLE:
  - Only i_valid=1: go to GRANT_I. Latch m_addr<=i_addr, m_wdata<=0, m_wstrb<=0, m_valid<=1.
  - Only d_valid=1: go to GRANT_D. Latch m_addr<=d_addr, m_wdata<=d_wdata, m_wstrb<=d_wstrb, m_valid<=1, grant_d<=1.
  - Both valid: PRIORITY=1 picks D. PRIORITY=0 picks the port opposite last_grant.
  - last_grant updates at grant time.
  - Neither valid: stay in IDLE, no master outputs change.
- Latency: a request seen in IDLE at edge N drives m_valid=1 from cycle N+1. Minimum requester round-trip is 2 cycles when m_ready arrives in the first grant cycle.
- GRANT_X:
  - m_valid is held; master outputs are stable until completion.
  - When m_ready=1: X_ready=X_valid combinationally in the same cycle and X_rdata=m_rdata.
  - At the next edge: m_valid<=0, m_wstrb<=0, grant_d<=0, counter<=0, state<=IDLE.
  - The ungranted port's ready stays 0 and its rdata is 0.
- Requester contract: X_valid is held until X_ready.
  - If X_valid drops mid-grant, the master transaction still completes.
  - The response is discarded: X_ready is gated by X_valid.
- Back-to-back: there is always at least one IDLE cycle between grants. An arbitration decision in that IDLE cycle sees requests waiting during the prior grant.
- Timeout (TIMEOUT>0):
  - The counter increments each GRANT cycle without m_ready.
  - When counter==TIMEOUT-1 and m_ready=0: X_ready=X_valid, X_rdata=0, err=1 for that cycle, then return to IDLE as on completion.
  - m_ready in the same cycle wins: normal completion, err=0.
- TIMEOUT=0: the counter is held at 0 and the grant waits indefinitely.
- Reset asserted mid-grant: all outputs return to reset values immediately. No ready pulse is issued.
- No combinational path from i_valid/d_valid to m_*.
- Combinational paths exist from m_ready/m_rdata to X_ready/X_rdata.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x100; memory returns m_ready=1 with m_rdata=0x00000013 on the first grant cycle.
  - Required: m_valid=1 one cycle after i_valid, m_wstrb=0.
  - Required: i_ready pulses exactly one cycle with i_rdata=0x13; d_ready stays 0.
- Store: d_valid=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF; memory waits 3 cycles before m_ready.
  - Required: m_addr=0x2000, m_wdata=0xDEADBEEF, m_wstrb=0xF held stable for 3 cycles.
  - Required: d_ready pulses once, grant_d deasserts the next cycle.
- Simultaneous requests, PRIORITY=0, held across 4 transactions: grant order D, I, D, I.
- Same stimulus with PRIORITY=1: grants are all D while d_valid is held. With d_valid then dropped, I is granted next.
- TIMEOUT=8, memory never asserts m_ready on a data read.
  - Required: d_ready=1, d_rdata=0, err=1 on the 8th grant cycle.
  - Required: m_valid=0 the following cycle, and a pending i_valid is granted after one IDLE cycle.
- Reset pulsed on the 2nd cycle of a GRANT_I with a pending d_valid.
  - Required: m_valid=0 and i_ready=0 immediately.
  - Required: after reset release with both valid and PRIORITY=0, D is granted first.
